// File: rtl/bitsel_pkg.sv
// Shared types and constants for the sequential bit-select unit.
package bitsel_pkg;

  localparam int W64 = 64;
  localparam int W32 = 32;

  typedef enum logic [2:0] {
    SEL64_LSB = 3'b000,
    SEL32_LSB = 3'b001,
    SEL64_MSB = 3'b010,
    SEL32_MSB = 3'b011
  } func_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DONE
  } state_e;

  function automatic logic [6:0] not_found_pos(input logic is32);
    return is32 ? 7'(W32) : 7'(W64);
  endfunction

endpackage

// File: rtl/bitsel_chunk.sv
// One chunk of the scan: popcount, hit flag and in-chunk offset of the (k+1)-th set bit.
module bitsel_chunk
  import bitsel_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0]         chunk_i,
  input  logic [5:0]               k_i,
  input  logic                     msb_first_i,
  output logic [$clog2(CHUNK):0]   popcnt_o,
  output logic                     hit_o,
  output logic [$clog2(CHUNK)-1:0] offset_o
);

  localparam int OW = $clog2(CHUNK);
  localparam int PW = OW + 1;

  logic [6:0]    seen;
  logic [OW-1:0] idx;

  // Offset is always reported as an LSB-based bit index; only the walk order flips.
  always_comb begin
    seen     = '0;
    hit_o    = 1'b0;
    offset_o = '0;
    idx      = '0;
    for (int unsigned j = 0; j < CHUNK; j++) begin
      idx = msb_first_i ? OW'(CHUNK - 1 - j) : OW'(j);
      if (chunk_i[idx]) begin
        if (!hit_o && seen == {1'b0, k_i}) begin
          hit_o    = 1'b1;
          offset_o = idx;
        end
        seen = seen + 7'd1;
      end
    end
    popcnt_o = PW'(seen);
  end

endmodule

// File: rtl/bitsel_seq.sv
// Sequential bit-select: position of the k-th set bit, LSB- or MSB-first, one chunk per cycle.
// Optional macro BITSEL_EARLY_EXIT_EN leaves SCAN as soon as the target chunk is found.
module bitsel_seq
  import bitsel_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        din_valid,
  output logic        din_ready,
  input  logic [63:0] din_data,
  input  logic [2:0]  din_func,
  input  logic [5:0]  din_index,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic [63:0] dout_data
);

  localparam int OW = $clog2(CHUNK);

  state_e        state_q;
  logic [63:0]   data_q;
  logic          is32_q;
  logic          msb_q;
  logic [5:0]    k_q;
  logic [5:0]    c_q;
  logic          found_q;
  logic [6:0]    pos_q;
  logic          dout_valid_q;
  logic [63:0]   dout_data_q;

  logic [5:0]    nch;
  logic [5:0]    chunk_idx;
  logic [5:0]    base;
  logic [CHUNK-1:0] chunk;
  logic          last;
  logic [OW:0]   popcnt;
  logic          hit;
  logic [OW-1:0] offset;
  logic          req32;

  always_comb begin
    nch       = is32_q ? 6'(W32 / CHUNK) : 6'(W64 / CHUNK);
    chunk_idx = msb_q ? (nch - 6'd1 - c_q) : c_q;
    base      = 6'(chunk_idx * CHUNK);
    chunk     = data_q[base +: CHUNK];
    last      = (c_q == nch - 6'd1);
    req32     = (din_func == SEL32_LSB) || (din_func == SEL32_MSB);
  end

  bitsel_chunk #(.CHUNK(CHUNK)) u_chunk (
    .chunk_i     (chunk),
    .k_i         (k_q),
    .msb_first_i (msb_q),
    .popcnt_o    (popcnt),
    .hit_o       (hit),
    .offset_o    (offset)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      data_q       <= '0;
      is32_q       <= 1'b0;
      msb_q        <= 1'b0;
      k_q          <= '0;
      c_q          <= '0;
      found_q      <= 1'b0;
      pos_q        <= '0;
      dout_valid_q <= 1'b0;
      dout_data_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (din_valid) begin
            case (din_func)
              SEL64_LSB, SEL32_LSB, SEL64_MSB, SEL32_MSB: begin
                data_q  <= req32 ? {32'b0, din_data[31:0]} : din_data;
                is32_q  <= req32;
                msb_q   <= (din_func == SEL64_MSB) || (din_func == SEL32_MSB);
                k_q     <= din_index;
                c_q     <= '0;
                found_q <= 1'b0;
                state_q <= ST_SCAN;
              end
              default: begin
                pos_q   <= '0;
                state_q <= ST_DONE;
              end
            endcase
          end
        end
        ST_SCAN: begin
          c_q <= c_q + 6'd1;
          // Once found, k and pos freeze; the remaining chunks only burn cycles.
          if (!found_q) begin
            if (hit) begin
              pos_q   <= 7'(base) + 7'(offset);
              found_q <= 1'b1;
            end else begin
              k_q <= k_q - 6'(popcnt);
            end
          end
          if (last) begin
            state_q <= ST_DONE;
            if (!found_q && !hit) pos_q <= not_found_pos(is32_q);
          end
`ifdef BITSEL_EARLY_EXIT_EN
          if (!found_q && hit) state_q <= ST_DONE;
`endif
        end
        ST_DONE: begin
          if (!dout_valid_q) begin
            dout_valid_q <= 1'b1;
            dout_data_q  <= {57'b0, pos_q};
          end else if (dout_ready) begin
            dout_valid_q <= 1'b0;
            state_q      <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign din_ready  = (state_q == ST_IDLE);
  assign dout_valid = dout_valid_q;
  assign dout_data  = dout_data_q;

endmodule
